// File: rtl/mult_rr_scheduler_pkg.sv
// Shared constants and helpers for the round-robin multiplier scheduler.
// Provides default sizes, the round-robin selector and a one-hot encoder.
package mult_rr_scheduler_pkg;

    localparam int DEF_W    = 4;
    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;
    localparam int DEF_CNTW = 16;

    // Helpers work on a fixed maximum width; callers zero-extend/truncate.
    localparam int MAXREQ = 32;
    localparam int MAXIDW = 5;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [MAXREQ-1:0] rr_select(
        input logic [MAXREQ-1:0] req,
        input int                ptr,
        input int                n
    );
        logic [MAXREQ-1:0] g;
        logic              found;
        int                s;
        logic [MAXIDW-1:0] idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAXREQ; k++) begin
            s = ptr + k;
            if (s >= n) s = s - n;
            idx = MAXIDW'(s);
            if (k < n && !found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [MAXIDW-1:0] oh_to_idx(
        input logic [MAXREQ-1:0] oh
    );
        logic [MAXIDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAXREQ; i++) begin
            if (oh[i]) idx = idx | MAXIDW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at/after the pointer.
// Ports: req_i, ptr_i, enable_i -> grant_o (one-hot), grant_id_o, any_grant_o.
module mult_rr_scheduler_rr_arbiter
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            any_grant_o
);

    logic [NREQ-1:0] sel;

    assign sel         = NREQ'(rr_select(MAXREQ'(req_i), int'(ptr_i), NREQ));
    assign grant_o     = enable_i ? sel : '0;
    assign grant_id_o  = IDW'(oh_to_idx(MAXREQ'(grant_o)));
    assign any_grant_o = |grant_o;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one registered WxW multiplier among NREQ requesters, round-robin.
// Ports: clk, rst, enable, req_valid/a/b/ready, resp_valid/id/product,
//        stats_clr, busy_count (saturating grant-cycle counter).
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW,
    parameter int CNTW = DEF_CNTW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [2*W-1:0]    resp_product,
    input  logic              stats_clr,
    output logic [CNTW-1:0]   busy_count
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic            any_grant;
    logic [W-1:0]    a_sel, b_sel;
    logic [2*W-1:0]  prod_d;
    logic            resp_valid_q;
    logic [IDW-1:0]  resp_id_q;
    logic [2*W-1:0]  resp_product_q;
    logic [CNTW-1:0] busy_q, busy_d;

    // Gating with rst keeps req_ready low for the whole reset window.
    mult_rr_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .enable_i    (enable & ~rst),
        .grant_o     (grant),
        .grant_id_o  (gid),
        .any_grant_o (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
        end
    end

    // Grant is one-hot, so the loop acts as a plain operand mux.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    assign prod_d = (2*W)'(a_sel) * (2*W)'(b_sel);

    always_comb begin
        busy_d = busy_q;
        if (stats_clr) begin
            busy_d = '0;
        end else if (any_grant && busy_q != '1) begin
            busy_d = busy_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
            busy_q         <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= any_grant;
            busy_q       <= busy_d;
            if (any_grant) begin
                resp_id_q      <= gid;
                resp_product_q <= prod_d;
            end
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_product = resp_product_q;
    assign busy_count   = busy_q;

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one registered W-bit unsigned multiplier between NREQ requesters using round-robin arbitration and a valid/ready request handshake.
- Returns each product on a common response bus, tagged with the requester ID, one cycle after the request is accepted.
- Sits between the operand sources (per-lane controllers) and the shared multiplier datapath.
- Keeps a saturating utilisation counter for debug.

Parameters:
- W, 4, operand width; product width is 2*W.
- NREQ, 4, number of requesters; must be at least 2.
- IDW, 2, requester-ID width; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the utilisation counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- enable  input  1  when low, no new grants are issued.
- req_valid  input  NREQ  bit i asserts that requester i holds a request.
- req_a  input  NREQ*W  operand A for requester i, in bits [i*W +: W].
- req_b  input  NREQ*W  operand B for requester i, in bits [i*W +: W].
- req_ready  output  NREQ  one-hot grant; the request is accepted when valid and ready are both high.
- resp_valid  output  1  single-cycle pulse marking a valid product.
- resp_id  output  IDW  ID of the requester the product belongs to.
- resp_product  output  2*W  product A*B.
- stats_clr  input  1  synchronous clear of the utilisation counter.
- busy_count  output  CNTW  number of cycles in which a grant was issued; saturates.

Behaviour:
- Reset: all registers clear.
  - Priority pointer = 0.
  - resp_valid = 0, resp_id = 0, resp_product = 0, busy_count = 0.
  - req_ready = 0 while rst is high.
- Grant logic (combinational from req_valid, enable and pointer):
  - At most one bit of req_ready is set per cycle.
  - Search runs from the pointer index upward, modulo NREQ.
  - The first i with req_valid[i] = 1 receives req_ready[i] = 1.
  - If enable = 0 or req_valid = 0, then req_ready = 0.
- Pointer update:
  - On a grant to i, the pointer becomes (i+1) mod NREQ at the next edge.
  - With no grant, the pointer is unchanged.
  - Wrap-around: a grant to NREQ-1 sets the pointer to 0.
- Requesters must hold req_a and req_b stable while req_valid is high and unaccepted. req_valid may not be withdrawn before acceptance; the bench checks this.
- Datapath, at the edge following an accept in cycle t:
  - resp_product <= A_i*B_i, computed at full 2*W width with no truncation.
  - resp_id <= i.
  - resp_valid <= 1.
  - Latency is exactly 1 cycle; throughput is 1 product per cycle.
- No accept in cycle t: resp_valid <= 0 and resp_product/resp_id hold their last values.
- The response has no backpressure; consumers must sample on the resp_valid cycle.
- enable falling while a product is in flight: that product is still delivered, and only new grants stop.
- A requester may re-request in the cycle after its accept. It competes normally, so with other requesters active it waits at most NREQ-1 cycles (fairness bound).
- busy_count:
  - +1 on each cycle with a grant.
  - Saturates at 2**CNTW-1.
  - stats_clr sets it to 0; stats_clr wins over a simultaneous increment.
- Reset mid-operation: in-flight products are discarded, resp_valid drops immediately (asynchronous), and the pointer returns to 0.

Decomposition:
- Shared package holds:
  - the default constants W, NREQ, IDW, CNTW;
  - the function computing round-robin index selection (pointer, request vector) -> one-hot grant;
  - the one-hot-to-index encoder.
- Sub-module rr_arbiter (req vector, pointer register, enable -> grant, grant_id, any_grant) is natural. The multiplier and response register stay in the top.

Test Plan:
- Single requester: req_valid = 0001, A0 = 4'd13, B0 = 4'd11, held 3 cycles -> req_ready = 0001 each cycle; resp_valid on 3 consecutive cycles with resp_product = 8'd143 and resp_id = 0.
- All requesters, A = i+12, B = 15, held valid continuously -> grants rotate 0,1,2,3,0 and products are 180, 195, 210, 225, 180, each one cycle after its grant.
- Fairness/wrap: pointer at 3, req_valid = 1001 -> grant 3, then 0, then 3. No requester waits more than 3 cycles.
- enable dropped in the cycle after a grant to requester 2 (A = 15, B = 15) -> resp_product = 225 with resp_id = 2 on the next cycle; req_ready = 0 while enable is low; the pointer resumes at 3 when enable returns.
- Corner values A = 0, B = 15 and A = 15, B = 15 -> 0 and 225, with no truncation in the upper byte.
- Reset asserted asynchronously mid-stream -> resp_valid, busy_count and the pointer are 0 within the same cycle. The first grant after release goes to the lowest-index valid requester.
- busy_count with CNTW overridden to 3 and 10 grant cycles -> saturates at 7; stats_clr together with a grant -> reads 0.
